// File: rtl/fft_pair_feeder.sv
// Buffers a 16-sample complex frame, then streams the 8 radix-2 DIF butterfly
// operand pairs x[n], x[n+8] together with their sum and twiddle W16^n (Q16).
module fft_pair_feeder (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [31:0] in_real,
  input  logic signed [31:0] in_imag,
  output logic               in_ready,
  input  logic               hold,
  output logic               valid,
  output logic signed [31:0] real_b,
  output logic signed [31:0] imag_b,
  output logic signed [31:0] real_a,
  output logic signed [31:0] imag_a,
  output logic signed [31:0] Real_coff,
  output logic signed [31:0] Imag_coff,
  output logic signed [31:0] sum_real,
  output logic signed [31:0] sum_imag,
  output logic               done
);

  typedef enum logic {LOAD, FEED} state_t;

  state_t            state;
  logic [3:0]        wr_cnt;
  logic [3:0]        pair_cnt;
  logic signed [31:0] mem_re [16];
  logic signed [31:0] mem_im [16];

  logic [3:0]         idx_b;
  logic [3:0]         idx_a;
  logic signed [31:0] b_re, b_im, a_re, a_im;
  logic signed [31:0] tw_re, tw_im;

  assign idx_b = {1'b0, pair_cnt[2:0]};
  assign idx_a = {1'b1, pair_cnt[2:0]};
  assign b_re  = mem_re[idx_b];
  assign b_im  = mem_im[idx_b];
  assign a_re  = mem_re[idx_a];
  assign a_im  = mem_im[idx_a];

  always_comb begin
    tw_re = 32'sd65536;
    tw_im = 32'sd0;
    unique case (pair_cnt[2:0])
      3'd0: begin tw_re =  32'sd65536; tw_im =  32'sd0;     end
      3'd1: begin tw_re =  32'sd60547; tw_im = -32'sd25080; end
      3'd2: begin tw_re =  32'sd46341; tw_im = -32'sd46341; end
      3'd3: begin tw_re =  32'sd25080; tw_im = -32'sd60547; end
      3'd4: begin tw_re =  32'sd0;     tw_im = -32'sd65536; end
      3'd5: begin tw_re = -32'sd25080; tw_im = -32'sd60547; end
      3'd6: begin tw_re = -32'sd46341; tw_im = -32'sd46341; end
      3'd7: begin tw_re = -32'sd60547; tw_im = -32'sd25080; end
    endcase
  end

  // Frame storage has no reset: every frame overwrites all 16 entries.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      mem_re[wr_cnt] <= in_real;
      mem_im[wr_cnt] <= in_imag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      wr_cnt    <= '0;
      pair_cnt  <= '0;
      in_ready  <= 1'b1;
      valid     <= 1'b0;
      done      <= 1'b0;
      real_b    <= '0;
      imag_b    <= '0;
      real_a    <= '0;
      imag_a    <= '0;
      Real_coff <= '0;
      Imag_coff <= '0;
      sum_real  <= '0;
      sum_imag  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            if (wr_cnt == 4'd15) begin
              state    <= FEED;
              in_ready <= 1'b0;
              wr_cnt   <= '0;
            end else begin
              wr_cnt <= wr_cnt + 4'd1;
            end
          end
        end
        FEED: begin
          if (!hold) begin
            // pair_cnt reaching 8 means pair 7 is already on the outputs
            if (pair_cnt[3]) begin
              valid    <= 1'b0;
              done     <= 1'b1;
              state    <= LOAD;
              in_ready <= 1'b1;
              pair_cnt <= '0;
            end else begin
              valid     <= 1'b1;
              real_b    <= b_re;
              imag_b    <= b_im;
              real_a    <= a_re;
              imag_a    <= a_im;
              sum_real  <= b_re + a_re;
              sum_imag  <= b_im + a_im;
              Real_coff <= tw_re;
              Imag_coff <= tw_im;
              pair_cnt  <= pair_cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_pair_feeder.sv
// Directed bench for fft_pair_feeder: ramp, gapped/held, overflow, mid-frame
// reset and ignored-input frames against hand-derived operand tables.
module tb_fft_pair_feeder;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [31:0] in_real = '0;
  logic signed [31:0] in_imag = '0;
  logic               in_ready;
  logic               hold = 1'b0;
  logic               valid;
  logic signed [31:0] real_b, imag_b, real_a, imag_a;
  logic signed [31:0] Real_coff, Imag_coff, sum_real, sum_imag;
  logic               done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] fr_re [16];
  logic [31:0] fr_im [16];
  logic [31:0] tw_re [8];
  logic [31:0] tw_im [8];

  fft_pair_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_real(in_real),
    .in_imag(in_imag), .in_ready(in_ready), .hold(hold), .valid(valid),
    .real_b(real_b), .imag_b(imag_b), .real_a(real_a), .imag_a(imag_a),
    .Real_coff(Real_coff), .Imag_coff(Imag_coff), .sum_real(sum_real),
    .sum_imag(sum_imag), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pair(input int n);
    check($sformatf("real_b[%0d]", n), real_b, fr_re[n]);
    check($sformatf("imag_b[%0d]", n), imag_b, fr_im[n]);
    check($sformatf("real_a[%0d]", n), real_a, fr_re[n+8]);
    check($sformatf("imag_a[%0d]", n), imag_a, fr_im[n+8]);
    check($sformatf("sum_real[%0d]", n), sum_real, fr_re[n] + fr_re[n+8]);
    check($sformatf("sum_imag[%0d]", n), sum_imag, fr_im[n] + fr_im[n+8]);
    check($sformatf("Real_coff[%0d]", n), Real_coff, tw_re[n]);
    check($sformatf("Imag_coff[%0d]", n), Imag_coff, tw_im[n]);
    check($sformatf("done_in_feed[%0d]", n), {31'd0, done}, 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_data_or"}, real_b | imag_b | real_a | imag_a | sum_real | sum_imag, 32'd0);
    check({tag, "_coff_or"}, Real_coff | Imag_coff, 32'd0);
  endtask

  task automatic load(input int gaps, input logic hold_in);
    hold = hold_in;
    for (int k = 0; k < 16; k++) begin
      if (gaps != 0) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          tick();
        end
      end
      check($sformatf("in_ready_load[%0d]", k), {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_real  = fr_re[k];
      in_imag  = fr_im[k];
      tick();
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    check("in_ready_after_e0", {31'd0, in_ready}, 32'd0);
    check("valid_after_e0", {31'd0, valid}, 32'd0);
  endtask

  task automatic feed(input int hold_pair, input int hold_len, input int junk, input int stop_at);
    int vcnt = 0;
    if (junk != 0) begin
      in_valid = 1'b1;
      in_real  = 32'hDEAD;
      in_imag  = 32'hDEAD;
    end
    for (int n = 0; n < 8; n++) begin
      tick();
      check($sformatf("valid[%0d]", n), {31'd0, valid}, 32'd1);
      check($sformatf("in_ready_feed[%0d]", n), {31'd0, in_ready}, 32'd0);
      check_pair(n);
      vcnt++;
      if (n == stop_at) return;
      if (n == hold_pair) begin
        hold = 1'b1;
        for (int h = 0; h < hold_len; h++) begin
          tick();
          check($sformatf("valid_held[%0d]", n), {31'd0, valid}, 32'd1);
          check_pair(n);
          vcnt++;
        end
        hold = 1'b0;
      end
    end
    tick();
    in_valid = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("valid_after_frame", {31'd0, valid}, 32'd0);
    check("in_ready_after_frame", {31'd0, in_ready}, 32'd1);
    check("real_b_retained", real_b, fr_re[7]);
    check("sum_real_retained", sum_real, fr_re[7] + fr_re[15]);
    check("valid_cycles", vcnt, (hold_pair >= 0) ? 32'(8 + hold_len) : 32'd8);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    tw_re[0] = 32'd65536;    tw_im[0] = 32'd0;
    tw_re[1] = 32'd60547;    tw_im[1] = -32'd25080;
    tw_re[2] = 32'd46341;    tw_im[2] = -32'd46341;
    tw_re[3] = 32'd25080;    tw_im[3] = -32'd60547;
    tw_re[4] = 32'd0;        tw_im[4] = -32'd65536;
    tw_re[5] = -32'd25080;   tw_im[5] = -32'd60547;
    tw_re[6] = -32'd46341;   tw_im[6] = -32'd46341;
    tw_re[7] = -32'd60547;   tw_im[7] = -32'd25080;

    #2 rst = 1'b1;
    #1 check_cleared("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Ramp frame: pair 0 = (0, 8, 8), pair 7 = (7, 15, 22)
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = 32'(k);
      fr_im[k] = 32'd0;
    end
    load(0, 1'b0);
    feed(-1, 0, 0, -1);

    // Gapped load with hold asserted (no effect in LOAD), then 3 held cycles on pair 3
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = 32'(1000 * k + 7);
      fr_im[k] = 32'(-5 * k);
    end
    load(1, 1'b1);
    feed(3, 3, 0, -1);

    // Overflow wrap; hold on the closing edge defers done
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = 32'(k);
      fr_im[k] = 32'(k);
    end
    fr_re[0] = 32'h7FFF_FFFF;  fr_im[0] = 32'h7FFF_FFFF;
    fr_re[8] = 32'd1;          fr_im[8] = 32'd1;
    load(0, 1'b0);
    tick();
    check("ovf_sum_real", sum_real, 32'h8000_0000);
    check("ovf_sum_imag", sum_imag, 32'h8000_0000);
    for (int n = 1; n < 8; n++) begin
      tick();
      check_pair(n);
    end
    hold = 1'b1;
    repeat (2) begin
      tick();
      check("deferred_done", {31'd0, done}, 32'd0);
      check("deferred_valid", {31'd0, valid}, 32'd1);
      check("deferred_in_ready", {31'd0, in_ready}, 32'd0);
    end
    hold = 1'b0;
    tick();
    check("done_after_defer", {31'd0, done}, 32'd1);
    tick();

    // Reset during pair 4, then a fresh frame must start at index 0
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = 32'(k + 50);
      fr_im[k] = 32'(k);
    end
    load(0, 1'b0);
    feed(-1, 0, 0, 4);
    rst = 1'b1;
    #1 check_cleared("mid_reset");
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = 32'(100 + k);
      fr_im[k] = 32'd0;
    end
    load(0, 1'b0);
    tick();
    check("reload_b0", real_b, 32'd100);
    check("reload_a0", real_a, 32'd108);
    for (int n = 1; n < 8; n++) begin
      tick();
      check_pair(n);
    end
    tick();
    check("reload_done", {31'd0, done}, 32'd1);
    tick();

    // Junk input during FEED is ignored; a following frame proves wr_cnt untouched
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = 32'(-3 * k);
      fr_im[k] = 32'(200 + k);
    end
    load(0, 1'b0);
    feed(5, 2, 1, -1);
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = 32'(7 * k + 1);
      fr_im[k] = 32'(-k);
    end
    load(1, 1'b0);
    feed(-1, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_pair_feeder.md
FFT_PAIR_FEEDER -- requirements
Module: fft_pair_feeder

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- in_valid  in  1  input sample strobe
- in_real, in_imag  in  32 signed  input complex sample
- in_ready  out  1  block accepts samples
- hold  in  1  freeze pair emission
- valid  out  1  pair/coefficient outputs valid
- real_b, imag_b  out  32 signed  first operand x[n]
- real_a, imag_a  out  32 signed  second operand x[n+8]
- Real_coff, Imag_coff  out  32 signed  twiddle W16^n, Q16
- sum_real, sum_imag  out  32 signed  x[n]+x[n+8]
- done  out  1  one-cycle frame-complete pulse

Function
REQ-003 The block SHALL buffer 16 complex samples, then emit 8 radix-2 DIF butterfly pairs for a 16-point FFT.
REQ-004 FSM states SHALL be LOAD and FEED; reset state LOAD.
REQ-005 In LOAD, in_ready SHALL be 1, and each cycle with in_valid=1 SHALL store the sample at index wr_cnt (0..15), then increment wr_cnt.
REQ-006 The edge accepting sample 15 (E0) SHALL move the FSM to FEED, clear wr_cnt, and drive in_ready to 0.
REQ-007 In FEED, in_valid SHALL be ignored and the buffer SHALL be left unmodified.
REQ-008 In FEED with hold=0, each edge SHALL register pair n (n=0..7 ascending) with valid=1:
- real_b/imag_b = x[n]
- real_a/imag_a = x[n+8]
- sum_real/sum_imag = x[n]+x[n+8]
- Real_coff/Imag_coff = W16^n
REQ-009 With hold=0 throughout, pair 0 SHALL appear after E1 and pair 7 after E8.
REQ-010 In FEED with hold=1, all outputs and the pair counter SHALL be held, valid included.
REQ-011 The hold=1 cycles SHALL delay subsequent pairs one-for-one.
REQ-012 The first unheld edge after pair 7 is registered SHALL do all of the following:
- clear valid
- pulse done=1 for exactly one cycle
- return the FSM to LOAD, so that in_ready is 1 from that cycle
REQ-013 A hold asserted on that edge SHALL defer it.
REQ-014 Sums SHALL be 32-bit two's-complement with wrap-around, with no saturation.
REQ-015 Twiddle table SHALL be constant Q16, in the form n:(Real,Imag):
- 0:(65536,0)
- 1:(60547,-25080)
- 2:(46341,-46341)
- 3:(25080,-60547)
- 4:(0,-65536)
- 5:(-25080,-60547)
- 6:(-46341,-46341)
- 7:(-60547,-25080)
REQ-016 When valid=0, data outputs SHALL retain their last values.
REQ-017 Gaps in in_valid during LOAD SHALL be tolerated without loss or reordering.
REQ-018 hold SHALL have no effect in LOAD.

Reset
REQ-019 On rst=1 the following SHALL happen immediately, asynchronously:
- FSM to LOAD
- wr_cnt and pair counter cleared
- valid=0, done=0, in_ready=1
- all 32-bit outputs cleared to 0
REQ-020 Buffer contents after reset SHALL be don't-care, because a new frame always fully overwrites them.
REQ-021 A reset asserted mid-LOAD or mid-FEED SHALL abandon the frame.
REQ-022 After a mid-frame reset, the next accepted sample SHALL be index 0.

Verification
REQ-023 The bench SHALL cover the following scenarios:
- Reset: assert rst -> in_ready=1, valid=0, done=0, all outputs 0.
- Ramp frame: x[k]=k+0j for k=0..15, contiguous -> 8 valid cycles after E1..E8, then done on the next cycle. Pair 0: b=0, a=8, sum=8, coff=(65536,0). Pair 7: b=7, a=15, sum=22, coff=(-60547,-25080).
- Hold and gapped input: load samples with random in_valid gaps, then hold=1 for 3 cycles during pair 3 -> pair 3 held for 4 cycles, total valid cycles = 11, pair order intact, done delayed by 3 cycles.
- Overflow: x[0]=0x7FFFFFFF+0x7FFFFFFFj, x[8]=1+1j -> sum_real = sum_imag = 0x80000000.
- Reset mid-FEED: rst during pair 4, then reload x[k]=100+k -> outputs cleared, new frame pair 0: b=100, a=108.
- Input during FEED: in_valid=1 with 0xDEAD samples throughout FEED -> ignored, in_ready=0, output pairs unchanged.
